// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: request payload and FSM states.
package wb_port_arbiter_pkg;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, PEND, DRAIN} wb_arb_state_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback, late-result and register-file port bundle of wb_port_arbiter.
// Forwarding signals exist only when WB_ARB_FWD_EN is defined.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic              wb_valid;
  logic              wb_we;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [RD_W-1:0]   lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              stall_req;
  logic              rf_we;
  logic [RD_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
`ifdef WB_ARB_FWD_EN
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output wb_valid, wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, stall_req, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
  );
  modport slave (
    input  wb_valid, wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, stall_req, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
  );
`else
  modport master (
    output wb_valid, wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, stall_req, rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    input  wb_valid, wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, stall_req, rf_we, rf_waddr, rf_wdata
  );
`endif
endinterface

// File: rtl/wb_arb_fifo.sv
// Synchronous FIFO of late write-back requests; head is the combinational oldest entry.
module wb_arb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstf,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // At full the slot being popped is the one written, so a simultaneous push is safe.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rstf) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, late results queue and force a drain stall
// when starved. Optional WB_ARB_FWD_EN exposes the current-cycle winner for decode bypass.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BUF_DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rstf,
  wb_port_arbiter_if.slave   bus
);
  localparam int         CNT_W      = $clog2(BUF_DEPTH) + 1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic             live;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  wb_req_t          head;
  wb_req_t          lu_req;
  wb_req_t          win;
  logic             win_vld;
  logic [3:0]       starve_cnt;
  logic [3:0]       starve_nxt;
  wb_arb_state_t    state;
  logic             stall_req_q;
  logic             rf_we_q;
  logic [RD_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  assign live          = bus.wb_valid && bus.wb_we && (bus.wb_rd != '0);
  assign bus.lu_ready  = !rstf && !full;
  // x0 late results complete the handshake but never occupy a slot.
  assign push          = bus.lu_valid && bus.lu_ready && (bus.lu_rd != '0);
  assign pop           = !live && !empty;
  assign lu_req.rd     = bus.lu_rd;
  assign lu_req.data   = bus.lu_data;
  assign count_nxt     = count + CNT_W'(push) - CNT_W'(pop);

  wb_arb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rstf      (rstf),
    .push      (push),
    .push_data (lu_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    if (live) begin
      win_vld  = 1'b1;
      win.rd   = bus.wb_rd;
      win.data = bus.wb_data;
    end else if (!empty) begin
      win_vld = 1'b1;
      win     = head;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop)           starve_nxt = '0;
    else if (starve_cnt != 4'hF) starve_nxt = starve_cnt + 4'd1;
  end

  // Output register stage and arbitration FSM
  always_ff @(posedge clk) begin
    if (rstf) begin
      state       <= IDLE;
      stall_req_q <= 1'b0;
      starve_cnt  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      rf_we_q    <= win_vld;
      if (win_vld) begin
        rf_waddr_q <= win.rd;
        rf_wdata_q <= win.data;
      end
      case (state)
        IDLE:  if (push) state <= PEND;
        PEND: begin
          if (count_nxt == '0) begin
            state <= IDLE;
          end else if (starve_nxt >= STARVE_LIM) begin
            state       <= DRAIN;
            stall_req_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            state       <= IDLE;
            stall_req_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          stall_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_req = stall_req_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

`ifdef WB_ARB_FWD_EN
  assign bus.fwd_valid = win_vld && !rstf;
  assign bus.fwd_rd    = win.rd;
  assign bus.fwd_data  = win.data;
`endif

  // The pipeline keeps priority even while stalled so no result is lost; flag the violation.
  a_no_wb_during_stall: assert property (@(posedge clk) disable iff (rstf) !(live && stall_req_q));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int BUF_DEPTH    = 2;

  logic clk = 1'b0;
  logic rstf = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk  (clk),
    .rstf (rstf),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queued late results, cycles the head has waited, drain flag, expected rf port.
  wb_req_t     mq[$];
  int          m_wait  = 0;
  bit          m_drain = 1'b0;
  bit          e_we    = 1'b0;
  logic [4:0]  e_addr  = '0;
  logic [31:0] e_data  = '0;
  logic        seen_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic tick(input logic wv, input logic we, input logic [4:0] w_rd, input logic [31:0] w_d,
                      input logic lv, input logic [4:0] l_rd, input logic [31:0] l_d, input logic rs);
    bit      ready, live, had, popped, win_v;
    wb_req_t win;
    rstf         = rs;
    bus.wb_valid = wv;
    bus.wb_we    = we;
    bus.wb_rd    = w_rd;
    bus.wb_data  = w_d;
    bus.lu_valid = lv;
    bus.lu_rd    = l_rd;
    bus.lu_data  = l_d;
    #1;
    ready      = !rs && (mq.size() < BUF_DEPTH);
    seen_ready = bus.lu_ready;
    chk("lu_ready", bus.lu_ready, ready);
    live   = wv && we && (w_rd != 5'd0);
    had    = (mq.size() != 0);
    popped = 1'b0;
    win_v  = 1'b1;
    win    = '0;
    if (live) begin
      win.rd   = w_rd;
      win.data = w_d;
    end else if (had) begin
      win    = mq[0];
      popped = 1'b1;
    end else begin
      win_v = 1'b0;
    end
`ifdef WB_ARB_FWD_EN
    chk("fwd_valid", bus.fwd_valid, win_v && !rs);
    if (win_v && !rs) begin
      chk("fwd_rd", bus.fwd_rd, win.rd);
      chk("fwd_data", bus.fwd_data, win.data);
    end
`endif
    if (rs) begin
      mq.delete();
      m_wait  = 0;
      m_drain = 1'b0;
      e_we    = 1'b0;
      e_addr  = '0;
      e_data  = '0;
    end else begin
      if (popped) void'(mq.pop_front());
      e_we = win_v;
      if (win_v) begin
        e_addr = win.rd;
        e_data = win.data;
      end
      if (!had || popped) m_wait = 0;
      else if (m_wait < 15) m_wait = m_wait + 1;
      if (lv && ready && (l_rd != 5'd0)) begin
        wb_req_t nr;
        nr.rd   = l_rd;
        nr.data = l_d;
        mq.push_back(nr);
      end
      if (mq.size() == 0) m_drain = 1'b0;
      else if (m_wait >= STARVE_LIMIT) m_drain = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rf_we", bus.rf_we, e_we);
    chk("rf_waddr", bus.rf_waddr, e_addr);
    chk("rf_wdata", bus.rf_wdata, e_data);
    chk("stall_req", bus.stall_req, m_drain);
  endtask

  task automatic idle_until_empty();
    for (int i = 0; i < 20 && (mq.size() != 0 || m_drain); i++)
      tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_stall, wr_cyc, fall_cyc, stray, first_ready3;
    int pend_rd[$];
    int got[$];

    bus.wb_valid = 1'b0; bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0;
    @(posedge clk);
    #1;

    // Reset state
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd9, 1'b1);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_stall", bus.stall_req, 0);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("post_rst_ready", seen_ready, 1);

    // Plain pipeline write, then x0 and we=0 drops
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("wb_we", bus.rf_we, 1);
    chk("wb_addr", bus.rf_waddr, 5);
    chk("wb_data", bus.rf_wdata, 32'hDEAD_BEEF);
    tick(1'b1, 1'b1, 5'd0, 32'h1111_2222, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("wb_x0_drop", bus.rf_we, 0);
    chk("wb_x0_hold", bus.rf_wdata, 32'hDEAD_BEEF);
    tick(1'b1, 1'b0, 5'd6, 32'h3333_4444, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("wb_we0_drop", bus.rf_we, 0);

    // Single late result: write appears two cycles after handshake
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0);
    chk("lu_single_ready", seen_ready, 1);
    chk("lu_no_passthru", bus.rf_we, 0);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("lu_single_we", bus.rf_we, 1);
    chk("lu_single_addr", bus.rf_waddr, 7);
    chk("lu_single_data", bus.rf_wdata, 32'h1234);
    idle_until_empty();

    // Starvation: pipeline busy every allowed cycle, one late result at cycle 0
    first_stall = -1; wr_cyc = -1; fall_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      tick(!m_drain, 1'b1, 5'd9, $urandom, (k == 0), 5'd3, 32'h33, 1'b0);
      if (bus.stall_req && first_stall < 0) first_stall = k + 1;
      if (!bus.stall_req && first_stall >= 0 && fall_cyc < 0) fall_cyc = k + 1;
      if (bus.rf_we && bus.rf_waddr == 5'd3) wr_cyc = k + 1;
    end
    chk("starve_stall_cyc", first_stall, 5);
    chk("starve_wr_cyc", wr_cyc, 6);
    chk("starve_fall_cyc", fall_cyc, 6);
    idle_until_empty();

    // Three back-to-back late results against a blocked pipeline
    pend_rd = '{1, 2, 3};
    first_ready3 = -1;
    for (int k = 0; k < 30 && (pend_rd.size() != 0 || mq.size() != 0); k++) begin
      bit acc;
      int cur;
      cur = (pend_rd.size() != 0) ? pend_rd[0] : 0;
      acc = (pend_rd.size() != 0) && (mq.size() < BUF_DEPTH);
      tick(!m_drain, 1'b1, 5'd10, $urandom, pend_rd.size() != 0, 5'(cur), 32'(cur * 16), 1'b0);
      if (cur == 3 && first_ready3 < 0) first_ready3 = seen_ready;
      if (acc) void'(pend_rd.pop_front());
      if (bus.rf_we && bus.rf_waddr < 5'd4) got.push_back(int'(bus.rf_waddr));
    end
    chk("third_blocked", first_ready3, 0);
    chk("order_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("order_rd", got[i], i + 1);
    idle_until_empty();

    // Reset while draining with two entries queued
    tick(1'b1, 1'b1, 5'd9, 32'd1, 1'b1, 5'd20, 32'hA0, 1'b0);
    tick(1'b1, 1'b1, 5'd9, 32'd2, 1'b1, 5'd21, 32'hA1, 1'b0);
    for (int k = 0; k < 20 && !m_drain; k++)
      tick(1'b1, 1'b1, 5'd9, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("pre_rst_stall", bus.stall_req, 1);
    chk("pre_rst_depth", mq.size(), 2);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("mid_rst_we", bus.rf_we, 0);
    chk("mid_rst_addr", bus.rf_waddr, 0);
    chk("mid_rst_data", bus.rf_wdata, 0);
    chk("mid_rst_stall", bus.stall_req, 0);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      if (bus.rf_we && (bus.rf_waddr == 5'd20 || bus.rf_waddr == 5'd21)) stray++;
    end
    chk("rst_discard", stray, 0);

    // Random traffic in segments of varying pipeline density
    for (int i = 0; i < 600; i++) begin
      int  dens;
      bit  rs, wv;
      dens = (i / 100) % 3;
      rs   = ($urandom_range(0, 79) == 0);
      wv   = !m_drain && ($urandom_range(0, 9) < (dens == 0 ? 3 : (dens == 1 ? 7 : 10)));
      tick(wv, $urandom_range(0, 7) != 0, 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom), $urandom, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order writeback stage and a long-latency return channel (load-miss / mul-div results). Pipeline writes win by fixed priority. Late results wait in a small FIFO. If a late result waits too long, the block requests a pipeline stall so it can drain. It sits between instruction writeback and the register file and is the only driver of the register-file write port.

## Interface
- STARVE_LIMIT, 4: cycles a FIFO head may wait unserved before a stall is requested (1..15).
- BUF_DEPTH, 2: late-result FIFO entries (power of two, ≥2).

- clk  in  1  clock; all state updates on rising edge.
- rstf  in  1  reset, synchronous, active-high.
- wb_valid  in  1  writeback stage presents a result this cycle (no back-pressure).
- wb_we  in  1  result writes a register.
- wb_rd  in  5  destination register.
- wb_data  in  32  result value.
- lu_valid  in  1  late-result request.
- lu_ready  out  1  late-result accepted when lu_valid&&lu_ready.
- lu_rd  in  5  late-result destination.
- lu_data  in  32  late-result value.
- stall_req  out  1  registered; pipeline must hold wb_valid=0 while high.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).

## Operation
- Pipeline request is "live" when wb_valid && wb_we && wb_rd!=0. Writes to x0 and we=0 results are dropped and do not use the port.
- A late result with lu_rd==0 is handshaken (accepted) but not enqueued.
- Per cycle: a live pipeline request wins. Otherwise, if the FIFO is non-empty, pop its head. The winner is registered onto rf_*. If there is no winner, rf_we=0 next cycle and rf_waddr/rf_wdata hold their values.
- lu_ready = !full, based on the count at the start of the cycle. Push and pop in the same cycle are legal at any fill level, including full.
- starve_cnt (4 bits) increments each cycle the FIFO is non-empty and not popped. It clears on any pop or when the FIFO is empty.
- FSM:
  - IDLE: FIFO empty. Goes to PEND on push.
  - PEND: FIFO non-empty, stall_req=0. Goes to IDLE when the FIFO becomes empty. Goes to DRAIN when starve_cnt reaches STARVE_LIMIT.
  - DRAIN: stall_req=1. Pops one entry per cycle. Goes to IDLE when the FIFO becomes empty, with stall_req falling the same edge.
- New pushes during DRAIN are accepted and extend DRAIN. DRAIN lasts at most BUF_DEPTH+pushes cycles.
- Contract violation (wb_valid live while stall_req=1): the pipeline still wins so no result is lost, and an assertion fires.
- Reset: FIFO empty, FSM=IDLE, starve_cnt=0, stall_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, lu_ready=0 while rstf=1. Any content mid-operation is discarded.

## Timing
- Pipeline write: input in cycle N, rf_we in cycle N+1. No bubble.
- Late result: handshake in cycle N, earliest rf_we in cycle N+2. There is no pass-through from lu_* to rf_*.
- stall_req rises on the edge after starve_cnt reaches STARVE_LIMIT. With a continuously blocked head, the first stalled pop is visible as rf_we in cycle +STARVE_LIMIT+2 after the enqueue.
- lu_ready is 1 in the first cycle after rstf deasserts.
- Write ordering to the same rd is not enforced. Hazard tracking belongs to the issue logic.

## Configuration
- WB_ARB_FWD_EN defined:
  - Adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (32). These are the unregistered winner of the current cycle, so decode can bypass.
  - fwd_valid is 0 when there is no winner and during reset.
- WB_ARB_FWD_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- The shared core package gets:
  - wb_req_t: packed struct {logic[4:0] rd; logic[31:0] data;}.
  - wb_arb_state_t enum {IDLE, PEND, DRAIN}.
- Sub-module wb_arb_fifo: synchronous FIFO of wb_req_t with parameter DEPTH, and push/pop/full/empty/head ports. Count width is $clog2(DEPTH)+1.
- Arbitration, the FSM, starve_cnt and the output registers live in the top module.

## Test plan
- wb_valid=1, wb_we=1, wb_rd=5, wb_data=0xDEAD_BEEF at cycle 10 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 11. With wb_rd=0 -> rf_we stays 0.
- Single lu push (rd=7, data=0x1234) with the pipeline idle -> rf_we with waddr=7 two cycles after the handshake. lu_ready stays 1.
- Pipeline live every cycle and lu pushes rd=3 at cycle 0, STARVE_LIMIT=4 -> stall_req=1 at cycle 5, rf write of rd=3 at cycle 6, stall_req=0 at cycle 6.
- Three lu pushes back-to-back while pipeline-blocked, BUF_DEPTH=2 -> lu_ready=0 on the third attempt. The third is accepted after the first pop. All three are written in order.
- rstf pulsed for 1 cycle with 2 entries queued and stall_req=1 -> all outputs 0 the next cycle, no queued write ever appears, FSM=IDLE.
- With WB_ARB_FWD_EN: fwd_valid/fwd_rd/fwd_data equal the next-cycle rf_* values every cycle across random traffic.
